adder_result_checker: RTL and testbench

Synthesizable response checker for the ripple-carry adder family. It accepts operand vectors on a valid/ready handshake and drives them to the adder under test. After a fixed settle latency it samples the adder's sum/carry and compares them against a golden a+b+cin. It keeps pass/error statistics and records the first failing vector, so adder checks can run on-chip or under a bench without per-vector waveform inspection.

---
 rtl/adder_result_checker.sv | 124 ++++++++++++
 tb/tb_adder_result_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Response checker for the ripple-carry adder family: drives registered operands to the
// adder under test, samples its result after LAT edges and keeps pass/error statistics.
module adder_result_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_stats,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic             vec_cin,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             result_valid,
  output logic             result_pass,
  output logic [CNT_W-1:0] checked_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin,
  output logic [WIDTH:0]   first_err_got
);

  localparam int LCW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

  state_t           state;
  state_t           next_state;
  logic [LCW-1:0]   wait_cnt;
  logic [WIDTH:0]   expected;
  logic [WIDTH:0]   observed;
  logic             accept;
  logic             match;

  assign vec_ready = (state == IDLE);
  assign accept    = vec_valid && vec_ready;
  assign observed  = {dut_cout, dut_sum};
  assign match     = (observed == expected);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (LAT == 1) ? CHECK : SETTLE;
      SETTLE:  if (wait_cnt == LCW'(LAT - 1)) next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // wait_cnt tracks how many edges have passed since acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        wait_cnt <= LCW'(1);
      end else if (state == SETTLE) begin
        wait_cnt <= wait_cnt + LCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dut_a    <= '0;
      dut_b    <= '0;
      dut_cin  <= 1'b0;
      expected <= '0;
    end else if (accept) begin
      dut_a    <= vec_a;
      dut_b    <= vec_b;
      dut_cin  <= vec_cin;
      expected <= {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
    end else begin
      result_valid <= (state == CHECK);
      result_pass  <= (state == CHECK) && match;
    end
  end

  // A clear coinciding with the compare edge wins, so that compare goes uncounted
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      checked_count <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_cin <= 1'b0;
      first_err_got <= '0;
    end else if (state == CHECK) begin
      if (checked_count != CNT_MAX) checked_count <= checked_count + CNT_W'(1);
      if (!match) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        err_flag <= 1'b1;
        if (!err_flag) begin
          first_err_a   <= dut_a;
          first_err_b   <= dut_b;
          first_err_cin <= dut_cin;
          first_err_got <= observed;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized self-checking bench for adder_result_checker; a wide-counter and a
// saturating narrow-counter instance share one stimulus stream and one adder model.
module tb_adder_result_checker;

  localparam int WIDTH = 4;
  localparam int LAT   = 2;
  localparam int MAX_W = 255;
  localparam int MAX_S = 3;

  logic       clk = 1'b0;
  logic       reset, clr_stats, vec_valid, vec_cin;
  logic [3:0] vec_a, vec_b;
  logic       vec_ready, vec_ready_s;
  logic [3:0] dut_a, dut_b, dut_a_s, dut_b_s;
  logic       dut_cin, dut_cin_s;
  logic [3:0] dut_sum;
  logic       dut_cout;
  logic       result_valid, result_pass, result_valid_s, result_pass_s;
  logic [7:0] checked_count, err_count;
  logic [1:0] checked_count_s, err_count_s;
  logic       err_flag, err_flag_s;
  logic [3:0] first_err_a, first_err_b, first_err_a_s, first_err_b_s;
  logic       first_err_cin, first_err_cin_s;
  logic [4:0] first_err_got, first_err_got_s;
  logic       fault_en;
  logic [4:0] fault_val;

  int checks = 0;
  int errors = 0;
  int m_chk, m_err, m_flag, m_fa, m_fb, m_fcin, m_fgot;

  always #5 clk = ~clk;

  // Adder under test: correct unless a fault value is being forced
  assign {dut_cout, dut_sum} = fault_en ? fault_val
                             : ({1'b0, dut_a} + {1'b0, dut_b} + {4'b0000, dut_cin});

  adder_result_checker #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .clr_stats(clr_stats),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .result_valid(result_valid), .result_pass(result_pass),
    .checked_count(checked_count), .err_count(err_count), .err_flag(err_flag),
    .first_err_a(first_err_a), .first_err_b(first_err_b),
    .first_err_cin(first_err_cin), .first_err_got(first_err_got)
  );

  adder_result_checker #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(2)) u_dut_s (
    .clk(clk), .reset(reset), .clr_stats(clr_stats),
    .vec_valid(vec_valid), .vec_ready(vec_ready_s),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin),
    .dut_a(dut_a_s), .dut_b(dut_b_s), .dut_cin(dut_cin_s),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .result_valid(result_valid_s), .result_pass(result_pass_s),
    .checked_count(checked_count_s), .err_count(err_count_s), .err_flag(err_flag_s),
    .first_err_a(first_err_a_s), .first_err_b(first_err_b_s),
    .first_err_cin(first_err_cin_s), .first_err_got(first_err_got_s)
  );

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    m_chk = 0; m_err = 0; m_flag = 0;
    m_fa = 0; m_fb = 0; m_fcin = 0; m_fgot = 0;
  endtask

  // Statistics as plain running totals; saturation is applied only when comparing
  task automatic modelUpdate(input int a, input int b, input int cin, input int got, input int clr);
    if (clr != 0) begin
      modelClear();
    end else begin
      m_chk++;
      if (got != a + b + cin) begin
        m_err++;
        if (m_flag == 0) begin
          m_fa = a; m_fb = b; m_fcin = cin; m_fgot = got;
        end
        m_flag = 1;
      end
    end
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, ".checked"},   32'(checked_count),   32'(sat(m_chk, MAX_W)));
    checkOutput({tag, ".errs"},      32'(err_count),       32'(sat(m_err, MAX_W)));
    checkOutput({tag, ".flag"},      32'(err_flag),        32'(m_flag));
    checkOutput({tag, ".fe_a"},      32'(first_err_a),     32'(m_fa));
    checkOutput({tag, ".fe_b"},      32'(first_err_b),     32'(m_fb));
    checkOutput({tag, ".fe_cin"},    32'(first_err_cin),   32'(m_fcin));
    checkOutput({tag, ".fe_got"},    32'(first_err_got),   32'(m_fgot));
    checkOutput({tag, ".checked_s"}, 32'(checked_count_s), 32'(sat(m_chk, MAX_S)));
    checkOutput({tag, ".errs_s"},    32'(err_count_s),     32'(sat(m_err, MAX_S)));
    checkOutput({tag, ".flag_s"},    32'(err_flag_s),      32'(m_flag));
    checkOutput({tag, ".fe_got_s"},  32'(first_err_got_s), 32'(m_fgot));
  endtask

  task automatic clearIdle();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    modelClear();
    checkStats("clr_idle");
  endtask

  // Sends one vector from a negedge and follows it to the end of its result pulse
  task automatic applyStimulus(input int a, input int b, input int cin,
                               input int fault, input int fgot, input int clr_at_check);
    int expv;
    int got;
    int waited;
    waited = 0;
    while (vec_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_accept", 32'(vec_ready), 32'd1);
    vec_a = 4'(a); vec_b = 4'(b); vec_cin = 1'(cin); vec_valid = 1'b1;
    fault_en = 1'(fault); fault_val = 5'(fgot);
    @(negedge clk);
    vec_valid = 1'b0;
    checkOutput("dut_a", 32'(dut_a), 32'(a));
    checkOutput("dut_b", 32'(dut_b), 32'(b));
    checkOutput("dut_cin", 32'(dut_cin), 32'(cin));
    for (int k = 1; k < LAT; k++) begin
      checkOutput("ready_settle", 32'(vec_ready), 32'd0);
      checkOutput("rv_settle", 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    checkOutput("ready_check", 32'(vec_ready), 32'd0);
    checkOutput("rv_check", 32'(result_valid), 32'd0);
    clr_stats = 1'(clr_at_check);
    @(negedge clk);
    clr_stats = 1'b0;
    expv = a + b + cin;
    got  = (fault != 0) ? fgot : expv;
    checkOutput("result_valid", 32'(result_valid), 32'd1);
    checkOutput("result_pass", 32'(result_pass), (got == expv) ? 32'd1 : 32'd0);
    checkOutput("result_valid_s", 32'(result_valid_s), 32'd1);
    checkOutput("ready_after", 32'(vec_ready), 32'd1);
    modelUpdate(a, b, cin, got, clr_at_check);
    checkStats("vec");
    @(negedge clk);
    fault_en = 1'b0;
    checkOutput("rv_pulse_end", 32'(result_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; clr_stats = 1'b0; vec_valid = 1'b0;
    vec_a = '0; vec_b = '0; vec_cin = 1'b0;
    fault_en = 1'b0; fault_val = '0;
    modelClear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", 32'(vec_ready), 32'd1);
    checkOutput("rst_rv", 32'(result_valid), 32'd0);
    checkOutput("rst_dut_a", 32'(dut_a), 32'd0);
    checkOutput("rst_dut_b", 32'(dut_b), 32'd0);
    checkOutput("rst_dut_cin", 32'(dut_cin), 32'd0);
    checkStats("rst");

    applyStimulus(3, 5, 0, 0, 0, 0);
    applyStimulus(15, 15, 1, 0, 0, 0);
    applyStimulus(15, 15, 1, 1, 30, 0);

    clearIdle();
    applyStimulus(1, 1, 0, 1, 3, 0);
    applyStimulus(2, 2, 0, 1, 5, 0);

    clearIdle();
    for (int i = 0; i < 5; i++) applyStimulus(i, 1, 0, 1, 31, 0);
    applyStimulus(7, 7, 1, 1, 0, 1);

    // Reset one cycle into SETTLE discards the vector
    applyStimulus(4, 4, 0, 1, 1, 0);
    vec_a = 4'd9; vec_b = 4'd4; vec_cin = 1'b1; vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    checkOutput("rs_dut_a", 32'(dut_a), 32'd9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    checkOutput("rs_ready", 32'(vec_ready), 32'd1);
    checkOutput("rs_dut_a_clr", 32'(dut_a), 32'd0);
    for (int k = 0; k <= LAT; k++) begin
      checkOutput("rs_no_rv", 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    checkStats("rs");

    // A vector held through SETTLE is taken only once ready returns
    vec_a = 4'd6; vec_b = 4'd7; vec_cin = 1'b0; vec_valid = 1'b1;
    @(negedge clk);
    vec_a = 4'd10; vec_b = 4'd11; vec_cin = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      checkOutput("hold_dut_a", 32'(dut_a), 32'd6);
      checkOutput("hold_ready", 32'(vec_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("hold_rv1", 32'(result_valid), 32'd1);
    checkOutput("hold_pass1", 32'(result_pass), 32'd1);
    checkOutput("hold_dut_a_kept", 32'(dut_a), 32'd6);
    modelUpdate(6, 7, 0, 13, 0);
    @(negedge clk);
    vec_valid = 1'b0;
    checkOutput("hold_dut_a_new", 32'(dut_a), 32'd10);
    repeat (LAT) @(negedge clk);
    checkOutput("hold_rv2", 32'(result_valid), 32'd1);
    checkOutput("hold_pass2", 32'(result_pass), 32'd1);
    modelUpdate(10, 11, 1, 22, 0);
    checkStats("hold");
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 29) == 0) clearIdle();
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                    int'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
